crot_rr_scheduler: RTL and testbench

//  Shares one fixed-latency CROT rotation datapath (pi/2, pi/4, pi/8 units, 3-cycle latency) among NUM_REQ
//  QFT stage requesters. Round-robin arbitration, one issue per cycle, angle-code select, result tagging by

---
 rtl/crot_rr_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_crot_rr_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crot_rr_scheduler.sv
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif

// Generic synchronous FIFO with occupancy count and registered storage.
// Latency: push visible at the head the cycle after the write; pop takes effect on the next edge.
// Backpressure: none internally; the caller must never push into a full FIFO unless it pops in the same cycle.
module crot_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_vld,
   input  logic [W-1:0]               push_dat,
   input  logic                       pop_rdy,
   output logic                       out_vld,
   output logic [W-1:0]               out_dat,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          do_pop;

   assign do_pop  = out_vld & pop_rdy;
   assign out_vld = (cnt != '0);
   // Head is forced to zero when empty so stale storage never shows on the outputs.
   assign out_dat = out_vld ? mem[rd_ptr] : '0;
   assign count   = cnt;

   // Storage write; entries carry no reset since occupancy is tracked separately.
   always_ff @(posedge clk) begin
      if (push_vld) mem[wr_ptr] <= push_dat;
   end

   // Pointer and occupancy bookkeeping; power-of-2 depth lets pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_vld) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({push_vld, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// Round-robin share of one fixed-latency CROT datapath among NUM_REQ requesters, results tagged by id.
// Latency: accept -> dp issue 1 cycle, dp issue -> result LAT cycles, result -> rsp_valid 1 cycle (LAT+2 total).
// Backpressure: credits (in flight + buffered < FIFO_DEPTH) gate req_ready so the unstallable datapath never overflows.
module crot_rr_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = `TOTAL_WIDTH,
   parameter int LAT        = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]    req_ar,
   input  logic [NUM_REQ*DATA_W-1:0]    req_ai,
   input  logic [NUM_REQ*2-1:0]         req_k,
   input  logic [NUM_REQ-1:0]           req_ctrl,
   output logic                         dp_valid,
   output logic [1:0]                   dp_k,
   output logic [DATA_W-1:0]            dp_ar,
   output logic [DATA_W-1:0]            dp_ai,
   input  logic [DATA_W-1:0]            dp_pr,
   input  logic [DATA_W-1:0]            dp_pi,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
   output logic [DATA_W-1:0]            rsp_pr,
   output logic [DATA_W-1:0]            rsp_pi,
   output logic                         busy
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int FW    = ID_W + 2 * DATA_W;

   logic [ID_W-1:0]  ptr;
   logic             can_issue;
   logic             grant_any;
   logic [ID_W-1:0]  grant_id;
   logic [ID_W:0]    idx;
   logic [ID_W-1:0]  sel;
   logic [CNT_W-1:0] inflight;
   logic [CNT_W-1:0] fifo_count;
   logic [ID_W-1:0]  dp_id;
   logic [LAT-1:0]   tag_vld;
   logic [ID_W-1:0]  tag_id [LAT];
   logic             tail_vld;
   logic [FW-1:0]    fifo_out;

   // Credit check on registered counts only; reset also blocks grants so req_ready reads zero while held.
   assign can_issue = !rst &&
                      (({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W+1)'(FIFO_DEPTH));

   // Rotating-priority search starting at ptr; first valid requester wins.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      idx       = '0;
      sel       = '0;
      for (int o = 0; o < NUM_REQ; o++) begin
         idx = {1'b0, ptr} + (ID_W+1)'(o);
         if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
         sel = idx[ID_W-1:0];
         if (can_issue && !grant_any && req_valid[sel]) begin
            grant_any = 1'b1;
            grant_id  = sel;
         end
      end
   end

   // One-hot ready for the granted requester only.
   always_comb begin
      req_ready = '0;
      if (grant_any) req_ready[grant_id] = 1'b1;
   end

   // Pointer moves just past the winner so it gets lowest priority next time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (grant_any) begin
         ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
   end

   // Issue register; operands and angle hold when idle, control bit off forces the identity code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_valid <= 1'b0;
         dp_k     <= 2'd0;
         dp_ar    <= '0;
         dp_ai    <= '0;
         dp_id    <= '0;
      end else begin
         dp_valid <= grant_any;
         if (grant_any) begin
            dp_k  <= req_ctrl[grant_id] ? req_k[grant_id*2 +: 2] : 2'd0;
            dp_ar <= req_ar[grant_id*DATA_W +: DATA_W];
            dp_ai <= req_ai[grant_id*DATA_W +: DATA_W];
            dp_id <= grant_id;
         end
      end
   end

   // Tag pipe tracks the datapath stage by stage so the tail lines up with dp_pr/dp_pi.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld <= '0;
         for (int s = 0; s < LAT; s++) tag_id[s] <= '0;
      end else begin
         tag_vld[0] <= dp_valid;
         tag_id[0]  <= dp_id;
         for (int s = 1; s < LAT; s++) begin
            tag_vld[s] <= tag_vld[s-1];
            tag_id[s]  <= tag_id[s-1];
         end
      end
   end

   assign tail_vld = tag_vld[LAT-1];

   // Ops between accept and FIFO push; counts the issue register as well as the tag pipe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight <= '0;
      end else begin
         case ({grant_any, tail_vld})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase
      end
   end

   crot_fifo #(
      .W     (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_rsp_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (tail_vld),
      .push_dat ({tag_id[LAT-1], dp_pr, dp_pi}),
      .pop_rdy  (rsp_ready),
      .out_vld  (rsp_valid),
      .out_dat  (fifo_out),
      .count    (fifo_count)
   );

   assign {rsp_id, rsp_pr, rsp_pi} = fifo_out;
   assign busy = (inflight != '0) | (fifo_count != '0) | dp_valid;

endmodule

// File: tb/tb_crot_rr_scheduler.sv
// Bench for crot_rr_scheduler: directed vector table plus scoreboard-checked streams.
// A behavioural 3-stage CROT datapath closes the loop from dp_* back to dp_pr/dp_pi.
// Inputs change 1ns after posedge; all observation happens on negedge.
module tb_crot_rr_scheduler;

   localparam int N     = 4;
   localparam int W     = 16;
   localparam int LAT   = 3;
   localparam int DEPTH = 8;
   localparam int IDW   = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid, req_ready, req_ctrl;
   logic [N*W-1:0]   req_ar, req_ai;
   logic [N*2-1:0]   req_k;
   logic             dp_valid;
   logic [1:0]       dp_k;
   logic [W-1:0]     dp_ar, dp_ai, dp_pr, dp_pi;
   logic             rsp_valid, rsp_ready;
   logic [IDW-1:0]   rsp_id;
   logic [W-1:0]     rsp_pr, rsp_pi;
   logic             busy;

   typedef struct {
      int         id;
      logic [W-1:0] ar;
      logic [W-1:0] ai;
      logic [1:0] k;
      logic       ctrl;
      logic [1:0] exp_k;
      logic [W-1:0] exp_pr;
      logic [W-1:0] exp_pi;
   } vec_t;

   typedef struct {
      logic [IDW-1:0] id;
      logic [W-1:0]   pr;
      logic [W-1:0]   pi;
   } exp_t;

   vec_t   vecs [6];
   exp_t   sb [$];
   int     grant_log [$];
   logic [N-1:0] acc_mask;
   int     acc_cnt, rsp_cnt;
   int     n_cmp, n_err;

   logic [W-1:0] p_pr [LAT];
   logic [W-1:0] p_pi [LAT];

   always #5 clk = ~clk;

   crot_rr_scheduler #(
      .NUM_REQ    (N),
      .DATA_W     (W),
      .LAT        (LAT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_ar    (req_ar),
      .req_ai    (req_ai),
      .req_k     (req_k),
      .req_ctrl  (req_ctrl),
      .dp_valid  (dp_valid),
      .dp_k      (dp_k),
      .dp_ar     (dp_ar),
      .dp_ai     (dp_ai),
      .dp_pr     (dp_pr),
      .dp_pi     (dp_pi),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_pr    (rsp_pr),
      .rsp_pi    (rsp_pi),
      .busy      (busy)
   );

   // CROT rotation by angle code in Q14 trig constants: identity, *i, pi/4, pi/8.
   function automatic logic [2*W-1:0] dp_model(input logic [1:0] k,
                                                input logic signed [W-1:0] ar,
                                                input logic signed [W-1:0] ai);
      int c, s, pr, pi;
      c = 0; s = 0; pr = 0; pi = 0;
      case (k)
         2'd0: begin pr = int'(ar);  pi = int'(ai); end
         2'd1: begin pr = -int'(ai); pi = int'(ar); end
         default: begin
            if (k == 2'd2) begin c = 11585; s = 11585; end
            else           begin c = 15137; s = 6270;  end
            pr = (int'(ar) * c - int'(ai) * s) >>> 14;
            pi = (int'(ar) * s + int'(ai) * c) >>> 14;
         end
      endcase
      return {pr[W-1:0], pi[W-1:0]};
   endfunction

   // Behavioural datapath: result appears LAT cycles after the issue cycle.
   always @(posedge clk) begin
      {p_pr[0], p_pi[0]} <= dp_model(dp_k, dp_ar, dp_ai);
      for (int s = 1; s < LAT; s++) begin
         p_pr[s] <= p_pr[s-1];
         p_pi[s] <= p_pi[s-1];
      end
   end
   assign dp_pr = p_pr[LAT-1];
   assign dp_pi = p_pi[LAT-1];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_lane(input int i, input logic [W-1:0] ar, input logic [W-1:0] ai,
                           input logic [1:0] k, input logic c);
      req_ar[i*W +: W] = ar;
      req_ai[i*W +: W] = ai;
      req_k[i*2 +: 2]  = k;
      req_ctrl[i]      = c;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 64'(req_ready), 0);
      check({tag, "_dp_valid"},  64'(dp_valid),  0);
      check({tag, "_dp_k"},      64'(dp_k),      0);
      check({tag, "_dp_ar"},     64'(dp_ar),     0);
      check({tag, "_dp_ai"},     64'(dp_ai),     0);
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
      check({tag, "_rsp_id"},    64'(rsp_id),    0);
      check({tag, "_rsp_pr"},    64'(rsp_pr),    0);
      check({tag, "_rsp_pi"},    64'(rsp_pi),    0);
      check({tag, "_busy"},      64'(busy),      0);
   endtask

   // Scoreboard: push expectation on each accept, pop and compare on each consumed result.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb.delete();
         end else begin
            check("ready_onehot", 64'($countones(req_ready) <= 1), 1);
            check("ready_without_valid", 64'(req_ready & ~req_valid), 0);
            for (int i = 0; i < N; i++) begin
               if (req_valid[i] && req_ready[i]) begin
                  e.id = IDW'(i);
                  {e.pr, e.pi} = dp_model(req_ctrl[i] ? req_k[i*2 +: 2] : 2'd0,
                                          req_ar[i*W +: W], req_ai[i*W +: W]);
                  sb.push_back(e);
                  grant_log.push_back(i);
                  acc_mask[i] = 1'b1;
                  acc_cnt++;
               end
            end
            if (rsp_valid && rsp_ready) begin
               rsp_cnt++;
               if (sb.size() == 0) begin
                  check("rsp_unexpected", 64'(rsp_valid), 0);
               end else begin
                  e = sb.pop_front();
                  check("rsp_order_data", 64'({rsp_id, rsp_pr, rsp_pi}), 64'({e.id, e.pr, e.pi}));
               end
            end
         end
      end
   endtask

   // Hold requests on mask for n cycles; lanes accepted last cycle get fresh random operands.
   task automatic stream(input int n, input logic [N-1:0] mask);
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            if (acc_mask[i])
               set_lane(i, W'($urandom), W'($urandom), 2'($urandom), 1'($urandom));
         end
         acc_mask  = '0;
         req_valid = mask;
      end
   endtask

   task automatic wait_idle(input string tag);
      for (int t = 0; t < 80; t++) begin
         @(negedge clk);
         if (!busy && !rsp_valid) break;
      end
      check({tag, "_idle_busy"}, 64'(busy), 0);
      check({tag, "_sb_empty"}, 64'(sb.size()), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat, a0, r0;
      logic seen;
      rst = 1'b1; req_valid = '0; req_ar = '0; req_ai = '0; req_k = '0; req_ctrl = '0;
      rsp_ready = 1'b1; acc_mask = '0; acc_cnt = 0; rsp_cnt = 0; n_cmp = 0; n_err = 0;

      vecs[0] = '{2, 16'h0100, 16'h0040, 2'd1, 1'b1, 2'd1, 16'hFFC0, 16'h0100};
      vecs[1] = '{1, 16'h1234, 16'hFFFB, 2'd3, 1'b0, 2'd0, 16'h1234, 16'hFFFB};
      vecs[2] = '{0, 16'h4000, 16'h0000, 2'd2, 1'b1, 2'd2, 16'h2D41, 16'h2D41};
      vecs[3] = '{3, 16'h4000, 16'h0000, 2'd3, 1'b1, 2'd3, 16'h3B21, 16'h187E};
      vecs[4] = '{1, 16'h0010, 16'h0020, 2'd0, 1'b1, 2'd0, 16'h0010, 16'h0020};
      vecs[5] = '{3, 16'h7FFF, 16'h8000, 2'd1, 1'b1, 2'd1, 16'h8000, 16'h7FFF};

      fork
         monitor();
      join_none

      #2;
      check_reset_outputs("por");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Three ops in flight, then asynchronous reset mid-cycle.
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) set_lane(i, W'(16'h0100 + i), W'(16'h0200 + i), 2'd1, 1'b1);
      acc_cnt   = 0;
      req_valid = 4'b0111;
      repeat (3) @(negedge clk);
      @(posedge clk); #1 req_valid = '0;
      check("pre_rst_accepts", 64'(acc_cnt), 3);
      check("pre_rst_busy", 64'(busy), 1);
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_rst");
      @(posedge clk); #1 rst = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      check("no_rsp_after_reset", 64'(seen), 0);
      check("idle_after_reset", 64'(busy), 0);

      // Fairness: all requesters held valid from pointer 0.
      grant_log.delete();
      stream(12, 4'hF);
      @(negedge clk);
      @(posedge clk); #1 req_valid = '0;
      check("fair_grant_count", 64'(grant_log.size()), 12);
      for (int i = 0; i < 12 && i < grant_log.size(); i++)
         check("fair_grant_order", 64'(grant_log[i]), 64'(i % N));
      wait_idle("fair");

      // Directed single-op vectors: angle select, control gating, latency, tagging.
      for (int v = 0; v < 6; v++) begin
         @(posedge clk); #1;
         set_lane(vecs[v].id, vecs[v].ar, vecs[v].ai, vecs[v].k, vecs[v].ctrl);
         req_valid = '0;
         req_valid[vecs[v].id] = 1'b1;
         for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready[vecs[v].id]) break;
         end
         check("vec_accept", 64'(req_ready[vecs[v].id]), 1);
         @(posedge clk); #1 req_valid = '0;
         @(negedge clk);
         check("vec_dp_valid", 64'(dp_valid), 1);
         check("vec_dp_k", 64'(dp_k), 64'(vecs[v].exp_k));
         check("vec_dp_ar", 64'({dp_ar, dp_ai}), 64'({vecs[v].ar, vecs[v].ai}));
         lat = 1;
         while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         check("vec_latency", 64'(lat), LAT + 2);
         check("vec_rsp_id", 64'(rsp_id), 64'(vecs[v].id));
         check("vec_rsp_pr", 64'(rsp_pr), 64'(vecs[v].exp_pr));
         check("vec_rsp_pi", 64'(rsp_pi), 64'(vecs[v].exp_pi));
      end
      wait_idle("vec");

      // Backpressure: exactly FIFO_DEPTH accepts, then ready drops.
      @(posedge clk); #1 rsp_ready = 1'b0;
      acc_cnt = 0;
      stream(20, 4'hF);
      @(negedge clk);
      check("bp_accepts", 64'(acc_cnt), DEPTH);
      check("bp_ready_low", 64'(req_ready), 0);
      check("bp_rsp_valid", 64'(rsp_valid), 1);

      // Release: drain in order while issuing; settles to push+pop+issue every cycle.
      @(posedge clk); #1 rsp_ready = 1'b1;
      stream(15, 4'hF);
      a0 = acc_cnt;
      r0 = rsp_cnt;
      stream(10, 4'hF);
      check("steady_accepts", 64'(acc_cnt - a0), 10);
      check("steady_rsps", 64'(rsp_cnt - r0), 10);
      @(posedge clk); #1 req_valid = '0;
      wait_idle("drain");
      check("drain_rsp_valid", 64'(rsp_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
